// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch-stage types, defaults and instruction field positions
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'b111111;
  localparam logic [31:0] PC_STEP             = 32'd4;

  // Instruction field positions, shared with the decode stage
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/instr_fetch_pc_unit.sv
// rtl/instr_fetch_pc_unit.sv - program counter with +4 step, redirect mux and word alignment
module instr_fetch_pc_unit
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_redirect,
  input  logic [31:0] redirect_pc,
  input  logic        incr,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next pc: redirect target (word aligned) wins over the sequential step; wraps modulo 2^32
  always_comb begin
    pc_d = pc_q;
    if (load_redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (incr) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // pc register, aligned reset value so the fetch address low bits stay zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with redirect and halt
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16,
  output logic        halted
);

  fetch_state_e state_d, state_q;
  logic [31:0]  instr_d, instr_q;
  logic [31:0]  pc_out_d, pc_out_q;
  logic         out_valid_d, out_valid_q;
  logic         halted_d, halted_q;
  logic         load_redirect;
  logic         incr;
  logic         issue;
  logic [31:0]  pc;

  instr_fetch_pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .clk          (clk),
    .rst          (rst),
    .load_redirect(load_redirect),
    .redirect_pc  (redirect_pc),
    .incr         (incr),
    .pc           (pc)
  );

  // Next-state and control: redirect beats both acceptance and halt detection
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    out_valid_d   = out_valid_q;
    halted_d      = halted_q;
    load_redirect = 1'b0;
    incr          = 1'b0;
    issue         = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        issue = 1'b1;
        if (redirect) begin
          load_redirect = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (redirect) begin
          load_redirect = 1'b1;
          out_valid_d   = 1'b0;
          state_d       = S_ISSUE;
        end else begin
          instr_d     = imem_data;
          pc_out_d    = pc;
          incr        = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          load_redirect = 1'b1;
          out_valid_d   = 1'b0;
          state_d       = S_ISSUE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (instr_q[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            issue   = 1'b1;
            state_d = S_CAPTURE;
          end
        end
      end
      S_HALT: begin
        out_valid_d = 1'b0;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // State and output registers; reset drops everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      instr_q     <= '0;
      pc_out_q    <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_en   = issue & ~rst;
  assign imem_addr = pc;
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;
  assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign rs        = instr_q[RS_MSB:RS_LSB];
  assign rt        = instr_q[RT_MSB:RT_LSB];
  assign imm16     = instr_q[IMM_MSB:IMM_LSB];

endmodule
